// File: rtl/decode_stage_pipe.sv
// RISC-V instruction-decode stage: register file, immediate generation, load-use detection, ID/EX register.
// Define WB_BYPASS_EN to return same-cycle write-back data on register reads (write-through).
module decode_stage_pipe #(
   parameter int XLEN        = 32,
   parameter int NREGS       = 32,
   parameter int CTRL_W      = 8,
   parameter int MEMREAD_BIT = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IF_ID_valid,
   input  logic [XLEN-1:0]   IF_ID_PC,
   input  logic [31:0]       IF_ID_instr,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [2:0]        immsel,
   input  logic              ID_EX_flush,
   input  logic              ex_hold,
   input  logic              MEM_WB_regwrite,
   input  logic [4:0]        MEM_WB_wr_reg,
   input  logic [XLEN-1:0]   MEM_WB_wr_data,
   output logic              stall,
   output logic              ID_EX_valid,
   output logic [XLEN-1:0]   ID_EX_PC,
   output logic [XLEN-1:0]   ID_EX_DAT1,
   output logic [XLEN-1:0]   ID_EX_DAT2,
   output logic [XLEN-1:0]   ID_EX_imm,
   output logic [4:0]        ID_EX_rd_reg1,
   output logic [4:0]        ID_EX_rd_reg2,
   output logic [4:0]        ID_EX_wr_reg,
   output logic [2:0]        ID_EX_funct3,
   output logic [6:0]        ID_EX_funct7,
   output logic [CTRL_W-1:0] ID_EX_ctrl
);

   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic [XLEN-1:0]   regs_r [NREGS];
   logic [AW-1:0]     rs1_idx_s;
   logic [AW-1:0]     rs2_idx_s;
   logic [AW-1:0]     wb_idx_s;
   logic [AW-1:0]     exrd_idx_s;
   logic              wb_en_s;
   logic [XLEN-1:0]   rd1_data_s;
   logic [XLEN-1:0]   rd2_data_s;
   logic signed [31:0] imm32_s;
   logic [XLEN-1:0]   imm_s;
   logic              load_use_s;
   logic              unused_ok_s;

   // Index bits above the register-file address width are ignored everywhere.
   assign rs1_idx_s  = IF_ID_instr[15 +: AW];
   assign rs2_idx_s  = IF_ID_instr[20 +: AW];
   assign wb_idx_s   = MEM_WB_wr_reg[AW-1:0];
   assign exrd_idx_s = ID_EX_wr_reg[AW-1:0];
   assign wb_en_s    = MEM_WB_regwrite && (wb_idx_s != '0);
   assign unused_ok_s = ^{IF_ID_instr[6:0], MEM_WB_wr_reg};

   // Register file write port; x0 is never written and write-back ignores pipeline control.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wb_en_s) begin
         regs_r[wb_idx_s] <= MEM_WB_wr_data;
      end else begin
         regs_r[wb_idx_s] <= regs_r[wb_idx_s];
      end
   end

   // Register file read ports.
   always_comb begin
      rd1_data_s = '0;
      rd2_data_s = '0;
`ifdef WB_BYPASS_EN
      if (wb_en_s && (wb_idx_s == rs1_idx_s)) begin
         rd1_data_s = MEM_WB_wr_data;
      end else if (rs1_idx_s != '0) begin
         rd1_data_s = regs_r[rs1_idx_s];
      end else begin
         rd1_data_s = '0;
      end
      if (wb_en_s && (wb_idx_s == rs2_idx_s)) begin
         rd2_data_s = MEM_WB_wr_data;
      end else if (rs2_idx_s != '0) begin
         rd2_data_s = regs_r[rs2_idx_s];
      end else begin
         rd2_data_s = '0;
      end
`else
      if (rs1_idx_s != '0) begin
         rd1_data_s = regs_r[rs1_idx_s];
      end else begin
         rd1_data_s = '0;
      end
      if (rs2_idx_s != '0) begin
         rd2_data_s = regs_r[rs2_idx_s];
      end else begin
         rd2_data_s = '0;
      end
`endif
   end

   // Immediate generation in 32 bits, then sign-extended to XLEN.
   always_comb begin
      imm32_s = '0;
      case (immsel)
         3'd0: imm32_s = {{20{IF_ID_instr[31]}}, IF_ID_instr[31:20]};
         3'd1: imm32_s = {{20{IF_ID_instr[31]}}, IF_ID_instr[31:25], IF_ID_instr[11:7]};
         3'd2: imm32_s = {{19{IF_ID_instr[31]}}, IF_ID_instr[31], IF_ID_instr[7],
                          IF_ID_instr[30:25], IF_ID_instr[11:8], 1'b0};
         3'd3: imm32_s = {IF_ID_instr[31:12], 12'h000};
         3'd4: imm32_s = {{11{IF_ID_instr[31]}}, IF_ID_instr[31], IF_ID_instr[19:12],
                          IF_ID_instr[20], IF_ID_instr[30:21], 1'b0};
         default: imm32_s = '0;
      endcase
   end

   assign imm_s = XLEN'(imm32_s);

   // rs2 is compared even for formats without rs2: a spurious stall is harmless.
   assign load_use_s = IF_ID_valid && ID_EX_valid && ID_EX_ctrl[MEMREAD_BIT] &&
                       (exrd_idx_s != '0) &&
                       ((exrd_idx_s == rs1_idx_s) || (exrd_idx_s == rs2_idx_s));

   assign stall = load_use_s || ex_hold;

   // ID/EX payload: reloaded unless EX holds; a flush overrides the hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         ID_EX_PC      <= '0;
         ID_EX_DAT1    <= '0;
         ID_EX_DAT2    <= '0;
         ID_EX_imm     <= '0;
         ID_EX_rd_reg1 <= '0;
         ID_EX_rd_reg2 <= '0;
         ID_EX_wr_reg  <= '0;
         ID_EX_funct3  <= '0;
         ID_EX_funct7  <= '0;
      end else if (ID_EX_flush || !ex_hold) begin
         ID_EX_PC      <= IF_ID_PC;
         ID_EX_DAT1    <= rd1_data_s;
         ID_EX_DAT2    <= rd2_data_s;
         ID_EX_imm     <= imm_s;
         ID_EX_rd_reg1 <= IF_ID_instr[19:15];
         ID_EX_rd_reg2 <= IF_ID_instr[24:20];
         ID_EX_wr_reg  <= IF_ID_instr[11:7];
         ID_EX_funct3  <= IF_ID_instr[14:12];
         ID_EX_funct7  <= IF_ID_instr[31:25];
      end else begin
         ID_EX_PC      <= ID_EX_PC;
         ID_EX_DAT1    <= ID_EX_DAT1;
         ID_EX_DAT2    <= ID_EX_DAT2;
         ID_EX_imm     <= ID_EX_imm;
         ID_EX_rd_reg1 <= ID_EX_rd_reg1;
         ID_EX_rd_reg2 <= ID_EX_rd_reg2;
         ID_EX_wr_reg  <= ID_EX_wr_reg;
         ID_EX_funct3  <= ID_EX_funct3;
         ID_EX_funct7  <= ID_EX_funct7;
      end
   end

   // ID/EX valid and control: flush and load-use bubbles clear them, hold keeps them.
   always_ff @(posedge clk) begin
      if (rst) begin
         ID_EX_valid <= 1'b0;
         ID_EX_ctrl  <= '0;
      end else if (ID_EX_flush) begin
         ID_EX_valid <= 1'b0;
         ID_EX_ctrl  <= '0;
      end else if (ex_hold) begin
         ID_EX_valid <= ID_EX_valid;
         ID_EX_ctrl  <= ID_EX_ctrl;
      end else if (load_use_s) begin
         ID_EX_valid <= 1'b0;
         ID_EX_ctrl  <= '0;
      end else begin
         ID_EX_valid <= IF_ID_valid;
         ID_EX_ctrl  <= IF_ID_valid ? ctrl_in : '0;
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomised self-checking bench for decode_stage_pipe against a behavioural pipeline model.
module tb_decode_stage_pipe;

   localparam int MRB = 5;

   logic        clk = 1'b0;
   logic        rst, IF_ID_valid, ID_EX_flush, ex_hold, MEM_WB_regwrite;
   logic [31:0] IF_ID_PC, IF_ID_instr, MEM_WB_wr_data;
   logic [7:0]  ctrl_in;
   logic [2:0]  immsel;
   logic [4:0]  MEM_WB_wr_reg;
   logic        stall, ID_EX_valid;
   logic [31:0] ID_EX_PC, ID_EX_DAT1, ID_EX_DAT2, ID_EX_imm;
   logic [4:0]  ID_EX_rd_reg1, ID_EX_rd_reg2, ID_EX_wr_reg;
   logic [2:0]  ID_EX_funct3;
   logic [6:0]  ID_EX_funct7;
   logic [7:0]  ID_EX_ctrl;

   int total = 0;
   int bad   = 0;

   // model of the architectural state and the ID/EX contents
   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [7:0]  m_ctrl;
   logic [31:0] m_pc, m_d1, m_d2, m_imm, m_instr;

   always #5 clk = ~clk;

   decode_stage_pipe dut (
      .clk(clk), .rst(rst), .IF_ID_valid(IF_ID_valid), .IF_ID_PC(IF_ID_PC),
      .IF_ID_instr(IF_ID_instr), .ctrl_in(ctrl_in), .immsel(immsel),
      .ID_EX_flush(ID_EX_flush), .ex_hold(ex_hold), .MEM_WB_regwrite(MEM_WB_regwrite),
      .MEM_WB_wr_reg(MEM_WB_wr_reg), .MEM_WB_wr_data(MEM_WB_wr_data), .stall(stall),
      .ID_EX_valid(ID_EX_valid), .ID_EX_PC(ID_EX_PC), .ID_EX_DAT1(ID_EX_DAT1),
      .ID_EX_DAT2(ID_EX_DAT2), .ID_EX_imm(ID_EX_imm), .ID_EX_rd_reg1(ID_EX_rd_reg1),
      .ID_EX_rd_reg2(ID_EX_rd_reg2), .ID_EX_wr_reg(ID_EX_wr_reg), .ID_EX_funct3(ID_EX_funct3),
      .ID_EX_funct7(ID_EX_funct7), .ID_EX_ctrl(ID_EX_ctrl)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // immediates computed arithmetically from the instruction value
   function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
      int s, sgn, t;
      s   = ins;
      sgn = s >>> 31;
      case (sel)
         3'd0: begin t = s >>> 20; return t; end
         3'd1: begin t = s >>> 25; return (t << 5) | ((ins >> 7) & 32'h1f); end
         3'd2: return (sgn << 12) | (((ins >> 7) & 32'h1) << 11) |
                      (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
         3'd3: return ins & 32'hFFFF_F000;
         3'd4: return (sgn << 20) | (((ins >> 12) & 32'hff) << 12) |
                      (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      logic [31:0] v;
      v = (idx == 5'd0) ? 32'h0 : m_regs[idx];
`ifdef WB_BYPASS_EN
      if (MEM_WB_regwrite && MEM_WB_wr_reg != 5'd0 && MEM_WB_wr_reg == idx) v = MEM_WB_wr_data;
`endif
      return v;
   endfunction

   task automatic idle();
      rst = 1'b0; IF_ID_valid = 1'b0; IF_ID_PC = 32'h0; IF_ID_instr = 32'h0; ctrl_in = 8'h0;
      immsel = 3'd0; ID_EX_flush = 1'b0; ex_hold = 1'b0; MEM_WB_regwrite = 1'b0;
      MEM_WB_wr_reg = 5'd0; MEM_WB_wr_data = 32'h0;
   endtask

   // one clock: check stall before the edge, advance the model, check ID/EX after the edge
   task automatic step();
      logic [4:0] rs1, rs2, mrd;
      logic       lu;
      rs1 = IF_ID_instr[19:15];
      rs2 = IF_ID_instr[24:20];
      mrd = m_instr[11:7];
      lu  = IF_ID_valid && m_valid && m_ctrl[MRB] && mrd != 5'd0 && (mrd == rs1 || mrd == rs2);
      @(negedge clk);
      if (!rst) check_eq("stall", {63'h0, stall}, {63'h0, lu || ex_hold});
      if (rst) begin
         m_valid = 1'b0; m_ctrl = 8'h0; m_pc = 32'h0; m_d1 = 32'h0; m_d2 = 32'h0;
         m_imm = 32'h0; m_instr = 32'h0;
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      end else begin
         if (ID_EX_flush || !ex_hold) begin
            m_pc = IF_ID_PC; m_d1 = ref_read(rs1); m_d2 = ref_read(rs2);
            m_imm = ref_imm(IF_ID_instr, immsel); m_instr = IF_ID_instr;
            if (ID_EX_flush || lu) begin
               m_valid = 1'b0; m_ctrl = 8'h0;
            end else begin
               m_valid = IF_ID_valid; m_ctrl = IF_ID_valid ? ctrl_in : 8'h0;
            end
         end
         if (MEM_WB_regwrite && MEM_WB_wr_reg != 5'd0) m_regs[MEM_WB_wr_reg] = MEM_WB_wr_data;
      end
      @(posedge clk);
      #1;
      check_eq("valid", {63'h0, ID_EX_valid}, {63'h0, m_valid});
      check_eq("ctrl", {56'h0, ID_EX_ctrl}, {56'h0, m_ctrl});
      if (m_valid) begin
         check_eq("pc", {32'h0, ID_EX_PC}, {32'h0, m_pc});
         check_eq("dat1", {32'h0, ID_EX_DAT1}, {32'h0, m_d1});
         check_eq("dat2", {32'h0, ID_EX_DAT2}, {32'h0, m_d2});
         check_eq("imm", {32'h0, ID_EX_imm}, {32'h0, m_imm});
         check_eq("fields", {39'h0, ID_EX_rd_reg1, ID_EX_rd_reg2, ID_EX_wr_reg, ID_EX_funct3, ID_EX_funct7},
                  {39'h0, m_instr[19:15], m_instr[24:20], m_instr[11:7], m_instr[14:12], m_instr[31:25]});
      end
   endtask

   task automatic decode(input logic [31:0] ins, input logic [2:0] sel, input logic [7:0] c);
      IF_ID_valid = 1'b1; IF_ID_instr = ins; immsel = sel; ctrl_in = c;
      IF_ID_PC = IF_ID_PC + 32'd4;
   endtask

   initial begin
      idle();
      m_valid = 1'b0; m_ctrl = 8'h0; m_instr = 32'h0;
      #2;
      // reset
      rst = 1'b1;
      step();
      check_eq("rst_all", {ID_EX_PC, ID_EX_DAT1 | ID_EX_DAT2 | ID_EX_imm},
               64'h0);
      check_eq("rst_fields", {23'h0, ID_EX_rd_reg1, ID_EX_rd_reg2, ID_EX_wr_reg, ID_EX_funct3,
               ID_EX_funct7, ID_EX_ctrl, ID_EX_valid}, 64'h0);
      idle();
      // x0 write dropped, all registers zero after reset
      MEM_WB_regwrite = 1'b1; MEM_WB_wr_reg = 5'd0; MEM_WB_wr_data = 32'hFFFF_FFFF;
      step();
      MEM_WB_regwrite = 1'b0;
      decode(32'h0000_0033, 3'd0, 8'h01);
      step();
      check_eq("x0_read", {32'h0, ID_EX_DAT1}, 64'h0);
      for (int i = 1; i < 32; i++) begin
         decode((32'(i) << 20) | (32'(i) << 15) | 32'h33, 3'd0, 8'h01);
         step();
         check_eq("rst_reg", {ID_EX_DAT1, ID_EX_DAT2}, 64'h0);
      end
      // addi x1,x1,-4
      decode(32'hFFC0_8093, 3'd0, 8'h03);
      step();
      check_eq("addi_imm", {32'h0, ID_EX_imm}, 64'hFFFF_FFFC);
      check_eq("addi_rd", {59'h0, ID_EX_wr_reg, ID_EX_valid}, 64'h3);
      // ex_hold for three cycles, then hold plus flush
      ex_hold = 1'b1;
      decode(32'h0012_8193, 3'd3, 8'h07);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("hold_imm", {32'h0, ID_EX_imm}, 64'hFFFF_FFFC);
         check_eq("hold_stall", {63'h0, stall}, 64'h1);
      end
      ID_EX_flush = 1'b1;
      step();
      check_eq("hold_flush", {55'h0, ID_EX_ctrl, ID_EX_valid}, 64'h0);
      ex_hold = 1'b0; ID_EX_flush = 1'b0;
      // load-use: lw x5, then add x6,x5,x7
      decode(32'h0001_2283, 3'd0, 8'h20);
      step();
      decode(32'h0072_8333, 3'd0, 8'h01);
      #1;
      check_eq("lu_stall", {63'h0, stall}, 64'h1);
      step();
      check_eq("lu_bubble", {55'h0, ID_EX_ctrl, ID_EX_valid}, 64'h0);
      step();
      check_eq("lu_reload", {58'h0, ID_EX_wr_reg, ID_EX_valid}, {58'h0, 5'd6, 1'b1});
      // lw x0 never stalls
      decode(32'h0001_2003, 3'd0, 8'h20);
      step();
      decode(32'h0070_0333, 3'd0, 8'h01);
      step();
      check_eq("lu_x0", {63'h0, ID_EX_valid}, 64'h1);
      // same-cycle write-back of x3
      IF_ID_valid = 1'b0;
      MEM_WB_regwrite = 1'b1; MEM_WB_wr_reg = 5'd3; MEM_WB_wr_data = 32'h55;
      step();
      MEM_WB_wr_data = 32'h1234;
      decode(32'h0001_8013, 3'd0, 8'h01);
      step();
`ifdef WB_BYPASS_EN
      check_eq("wb_same", {32'h0, ID_EX_DAT1}, 64'h1234);
`else
      check_eq("wb_same", {32'h0, ID_EX_DAT1}, 64'h55);
`endif
      MEM_WB_regwrite = 1'b0;
      // jal immediate, reserved immsel
      decode(32'h8000_006F, 3'd4, 8'h01);
      step();
      check_eq("jal_imm", {32'h0, ID_EX_imm}, 64'hFFF0_0000);
      immsel = 3'd6;
      step();
      check_eq("imm_zero", {32'h0, ID_EX_imm}, 64'h0);
      // randomised traffic
      for (int n = 0; n < 3000; n++) begin
         if (!(stall && $urandom_range(0, 3) != 0)) begin
            IF_ID_instr = $urandom;
            if ($urandom_range(0, 1) == 1) IF_ID_instr[19:15] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) IF_ID_instr[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) IF_ID_instr[11:7]  = 5'($urandom_range(0, 3));
            IF_ID_PC    = $urandom;
            IF_ID_valid = ($urandom_range(0, 4) != 0);
            ctrl_in     = 8'($urandom);
            immsel      = 3'($urandom_range(0, 7));
         end
         rst             = ($urandom_range(0, 199) == 0);
         ID_EX_flush     = ($urandom_range(0, 7) == 0);
         ex_hold         = ($urandom_range(0, 5) == 0);
         MEM_WB_regwrite = ($urandom_range(0, 1) == 1);
         MEM_WB_wr_reg   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         MEM_WB_wr_data  = $urandom;
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
